crc_stream_ctrl: RTL

- Sequencer that drives the memory-mapped CRC engine's register port.
- On a start pulse it programs polynomial and initial value, streams LEN bytes from a valid/ready byte source into the DATA (or REFL) register, and polls STAT between bytes.
- Then it reads back the CRC (plain or reflected), applies an output XOR and reports done.
- Sits between a byte producer (UART RX buffer, SPI, etc.) and the CRC engine, so the CPU does not have to feed bytes itself.

---
 rtl/crc_stream_ctrl_if.sv | 22 ++
 rtl/crc_stream_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_ctrl_if.sv
// crc_stream_ctrl_if: byte-source handshake plus CRC engine register port.
// The master side is the sequencer; the slave side is the source and engine.
interface crc_stream_ctrl_if;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        crc_cs;
    logic [1:0]  crc_rs;
    logic [3:0]  crc_wrl;
    logic [31:0] crc_d;
    logic [31:0] crc_q;

    modport master (
        input  s_valid, s_data, crc_q,
        output s_ready, crc_cs, crc_rs, crc_wrl, crc_d
    );

    modport slave (
        output s_valid, s_data, crc_q,
        input  s_ready, crc_cs, crc_rs, crc_wrl, crc_d
    );
endinterface

// File: rtl/crc_stream_ctrl.sv
// crc_stream_ctrl: streams LEN source bytes into the CRC engine and reads back.
// Define CRC_STREAM_WORD_EN to pack up to four bytes per engine write.
module crc_stream_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       cfg_poly,
    input  logic [31:0]       cfg_init,
    input  logic [31:0]       cfg_xorout,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_refin,
    input  logic              cfg_refout,
    crc_stream_ctrl_if.master bus,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLY,
        S_INIT,
        S_FETCH,
        S_WRITE,
        S_WAIT,
        S_READ,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [31:0]      poly_r;
    logic [31:0]      init_r;
    logic [31:0]      xorout_r;
    logic [31:0]      word_r;
    logic             refin_r;
    logic             refout_r;
    logic [LEN_W-1:0] remain;
    logic [1:0]       idx;
    logic [2:0]       grp;
    logic [3:0]       lanes;
    logic             grp_full;

    // Bytes packed into the next engine write, chosen from what is still owed.
    always_comb begin
        grp = 3'd1;
`ifdef CRC_STREAM_WORD_EN
        if (remain >= LEN_W'(4)) begin
            grp = 3'd4;
        end else if (remain >= LEN_W'(2)) begin
            grp = 3'd2;
        end
`endif
    end

    assign lanes    = 4'((5'd1 << grp) - 5'd1);
    assign grp_full = (({1'b0, idx} + 3'd1) == grp);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Job config capture, byte packing, remaining count and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poly_r   <= '0;
            init_r   <= '0;
            xorout_r <= '0;
            refin_r  <= 1'b0;
            refout_r <= 1'b0;
            remain   <= '0;
            idx      <= '0;
            word_r   <= '0;
            result   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        poly_r   <= cfg_poly;
                        init_r   <= cfg_init;
                        xorout_r <= cfg_xorout;
                        refin_r  <= cfg_refin;
                        refout_r <= cfg_refout;
                        remain   <= cfg_len;
                        idx      <= '0;
                        word_r   <= '0;
                    end
                end
                S_FETCH: begin
                    if (bus.s_valid) begin
                        word_r[{idx, 3'b000} +: 8] <= bus.s_data;
                        idx <= idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    remain <= remain - LEN_W'(grp);
                    idx    <= '0;
                    word_r <= '0;
                end
                S_READ: begin
                    result <= bus.crc_q ^ xorout_r;
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and engine port drive; engine is only written in POLY/INIT/WRITE.
    always_comb begin
        state_nx    = state;
        bus.s_ready = 1'b0;
        bus.crc_cs  = 1'b0;
        bus.crc_rs  = 2'b00;
        bus.crc_wrl = 4'b0000;
        bus.crc_d   = '0;
        done        = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_POLY;
                end
            end
            S_POLY: begin
                bus.crc_cs  = 1'b1;
                bus.crc_rs  = 2'b01;
                bus.crc_wrl = 4'b1111;
                bus.crc_d   = poly_r;
                state_nx    = S_INIT;
            end
            S_INIT: begin
                bus.crc_cs  = 1'b1;
                bus.crc_rs  = 2'b00;
                bus.crc_wrl = 4'b1111;
                bus.crc_d   = init_r;
                state_nx    = (remain == '0) ? S_READ : S_FETCH;
            end
            S_FETCH: begin
                bus.s_ready = 1'b1;
                bus.crc_rs  = 2'b01;
                if (bus.s_valid && grp_full) begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                bus.crc_cs  = 1'b1;
                bus.crc_rs  = refin_r ? 2'b11 : 2'b10;
                bus.crc_wrl = lanes;
                bus.crc_d   = word_r;
                state_nx    = S_WAIT;
            end
            S_WAIT: begin
                bus.crc_rs = 2'b01;
                if (bus.crc_q[0]) begin
                    state_nx = (remain == '0) ? S_READ : S_FETCH;
                end
            end
            S_READ: begin
                bus.crc_rs = refout_r ? 2'b10 : 2'b00;
                state_nx   = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule
